// File: rtl/sot_monitor_pkg.sv
// Shared types and constants for the start-of-frame lock supervisor.
package sot_monitor_pkg;

    localparam int DEF_NUM_VFATS     = 24;
    localparam int DEF_CNT_WIDTH     = 8;
    localparam int DEF_TIMEOUT_WIDTH = 16;

    // Aligner reset pulse length, in clock cycles.
    localparam int RETRY_CYCLES = 4;
    localparam int RETRY_CNT_W  = $clog2(RETRY_CYCLES);

    typedef enum logic [1:0] {
        ST_MASKED    = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_LOCKED    = 2'd2,
        ST_RETRY     = 2'd3
    } sot_state_t;

endpackage

// File: rtl/sot_monitor_channel.sv
// One VFAT's lock supervisor: FSM, acquisition timer, unlock counter, sticky flags.
// Optional feature macro: SOT_AUTO_RETRY_EN (timeout triggers an aligner reset pulse).
module sot_monitor_channel
    import sot_monitor_pkg::*;
#(
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset_i,
    input  logic                     sot_is_aligned,
    input  logic                     sot_unstable,
    input  logic                     vfat_mask,
    input  logic [TIMEOUT_WIDTH-1:0] align_timeout,
    input  logic                     cnt_reset,
    output logic                     vfat_ready,
    output logic                     timeout_err,
    output logic                     unstable_err,
    output logic [CNT_WIDTH-1:0]     unlock_cnt,
    output logic                     aligner_reset_o
);

    sot_state_t               state_q, state_d;
    logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
    logic [CNT_WIDTH-1:0]     cnt_q;
    logic                     ready_q;
    logic                     timeout_q;
    logic                     unstable_q;
    logic                     unstable_prev;
    logic                     inc_unlock;
    logic                     set_timeout;
    logic                     set_unstable;
`ifdef SOT_AUTO_RETRY_EN
    logic [RETRY_CNT_W-1:0]   retry_q, retry_d;
    logic                     areset_q;
`endif

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        inc_unlock  = 1'b0;
        set_timeout = 1'b0;
`ifdef SOT_AUTO_RETRY_EN
        retry_d     = retry_q;
`endif
        if (vfat_mask) begin
            state_d = ST_MASKED;
            timer_d = '0;
`ifdef SOT_AUTO_RETRY_EN
            retry_d = '0;
`endif
        end else begin
            case (state_q)
                ST_MASKED: begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end
                ST_WAIT_LOCK: begin
                    // Lock wins over a coincident timeout.
                    if (sot_is_aligned) begin
                        state_d = ST_LOCKED;
                        timer_d = '0;
                    end else begin
                        if (timer_q != '1)
                            timer_d = timer_q + TIMEOUT_WIDTH'(1);
                        if (align_timeout != '0 && timer_q == align_timeout) begin
                            set_timeout = 1'b1;
`ifdef SOT_AUTO_RETRY_EN
                            state_d = ST_RETRY;
                            timer_d = '0;
                            retry_d = '0;
`endif
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!sot_is_aligned) begin
                        state_d    = ST_WAIT_LOCK;
                        timer_d    = '0;
                        inc_unlock = 1'b1;
                    end
                end
`ifdef SOT_AUTO_RETRY_EN
                ST_RETRY: begin
                    if (retry_q == RETRY_CNT_W'(RETRY_CYCLES - 1)) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                        retry_d = '0;
                    end else begin
                        retry_d = retry_q + RETRY_CNT_W'(1);
                    end
                end
`endif
                default: begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end
            endcase
        end
    end

    assign set_unstable = !vfat_mask && sot_unstable && !unstable_prev;

    always_ff @(posedge clock) begin
        if (reset_i) begin
            state_q <= vfat_mask ? ST_MASKED : ST_WAIT_LOCK;
            timer_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ready_q <= (state_d == ST_LOCKED);
        end
    end

    // Slow-control counters and sticky flags; cnt_reset overrides any event.
    always_ff @(posedge clock) begin
        if (reset_i || cnt_reset) begin
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            unstable_q <= 1'b0;
        end else begin
            if (inc_unlock && cnt_q != '1)
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            if (set_timeout)
                timeout_q <= 1'b1;
            if (set_unstable)
                unstable_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        unstable_prev <= sot_unstable;
    end

`ifdef SOT_AUTO_RETRY_EN
    always_ff @(posedge clock) begin
        if (reset_i) begin
            retry_q  <= '0;
            areset_q <= 1'b0;
        end else begin
            retry_q  <= retry_d;
            areset_q <= (state_d == ST_RETRY);
        end
    end

    assign aligner_reset_o = areset_q;
`else
    assign aligner_reset_o = 1'b0;
`endif

    assign vfat_ready   = ready_q;
    assign timeout_err  = timeout_q;
    assign unstable_err = unstable_q;
    assign unlock_cnt   = cnt_q;

endmodule

// File: rtl/sot_monitor.sv
// Per-VFAT start-of-frame lock supervisor with registered aggregate ready.
// Optional feature macro: SOT_AUTO_RETRY_EN (see sot_monitor_channel).
module sot_monitor
    import sot_monitor_pkg::*;
#(
    parameter int NUM_VFATS     = DEF_NUM_VFATS,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH
) (
    input  logic                           clock,
    input  logic                           reset_i,
    input  logic [NUM_VFATS-1:0]           sot_is_aligned,
    input  logic [NUM_VFATS-1:0]           sot_unstable,
    input  logic [NUM_VFATS-1:0]           vfat_mask,
    input  logic [TIMEOUT_WIDTH-1:0]       align_timeout,
    input  logic                           cnt_reset,
    output logic [NUM_VFATS-1:0]           vfat_ready,
    output logic                           all_ready,
    output logic [NUM_VFATS-1:0]           timeout_err,
    output logic [NUM_VFATS-1:0]           unstable_err,
    output logic [NUM_VFATS*CNT_WIDTH-1:0] unlock_cnt,
    output logic [NUM_VFATS-1:0]           aligner_reset_o
);

    logic all_ready_q;

    for (genvar i = 0; i < NUM_VFATS; i++) begin : g_chan
        sot_monitor_channel #(
            .CNT_WIDTH     (CNT_WIDTH),
            .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
        ) u_chan (
            .clock           (clock),
            .reset_i         (reset_i),
            .sot_is_aligned  (sot_is_aligned[i]),
            .sot_unstable    (sot_unstable[i]),
            .vfat_mask       (vfat_mask[i]),
            .align_timeout   (align_timeout),
            .cnt_reset       (cnt_reset),
            .vfat_ready      (vfat_ready[i]),
            .timeout_err     (timeout_err[i]),
            .unstable_err    (unstable_err[i]),
            .unlock_cnt      (unlock_cnt[CNT_WIDTH*i +: CNT_WIDTH]),
            .aligner_reset_o (aligner_reset_o[i])
        );
    end

    // A fully masked detector is never reported as ready.
    always_ff @(posedge clock) begin
        if (reset_i)
            all_ready_q <= 1'b0;
        else
            all_ready_q <= (&(vfat_ready | vfat_mask)) && !(&vfat_mask);
    end

    assign all_ready = all_ready_q;

endmodule

// File: tb/tb_sot_monitor.sv
// Directed self-checking bench for sot_monitor (default widths).
module tb_sot_monitor;

    localparam int NV = 24;
    localparam int CW = 8;
    localparam int TW = 16;

    logic              clock = 1'b0;
    logic              reset_i;
    logic [NV-1:0]     sot_is_aligned;
    logic [NV-1:0]     sot_unstable;
    logic [NV-1:0]     vfat_mask;
    logic [TW-1:0]     align_timeout;
    logic              cnt_reset;
    logic [NV-1:0]     vfat_ready;
    logic              all_ready;
    logic [NV-1:0]     timeout_err;
    logic [NV-1:0]     unstable_err;
    logic [NV*CW-1:0]  unlock_cnt;
    logic [NV-1:0]     aligner_reset_o;

    int tests = 0;
    int fails = 0;

    sot_monitor dut (
        .clock           (clock),
        .reset_i         (reset_i),
        .sot_is_aligned  (sot_is_aligned),
        .sot_unstable    (sot_unstable),
        .vfat_mask       (vfat_mask),
        .align_timeout   (align_timeout),
        .cnt_reset       (cnt_reset),
        .vfat_ready      (vfat_ready),
        .all_ready       (all_ready),
        .timeout_err     (timeout_err),
        .unstable_err    (unstable_err),
        .unlock_cnt      (unlock_cnt),
        .aligner_reset_o (aligner_reset_o)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [CW-1:0] cnt_of(input int i);
        return unlock_cnt[i*CW +: CW];
    endfunction

    task automatic idle_all();
        vfat_mask      = '1;
        sot_is_aligned = '0;
        sot_unstable   = '0;
        step(2);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        step(2);
        tests++; if (vfat_ready !== '0) begin fails++; $display("FAIL reset_vfat_ready got %h exp 0", vfat_ready); end
        tests++; if (all_ready !== 1'b0) begin fails++; $display("FAIL reset_all_ready got %b exp 0", all_ready); end
        tests++; if (timeout_err !== '0) begin fails++; $display("FAIL reset_timeout_err got %h exp 0", timeout_err); end
        tests++; if (unstable_err !== '0) begin fails++; $display("FAIL reset_unstable_err got %h exp 0", unstable_err); end
        tests++; if (unlock_cnt !== '0) begin fails++; $display("FAIL reset_unlock_cnt got %h exp 0", unlock_cnt); end
        tests++; if (aligner_reset_o !== '0) begin fails++; $display("FAIL reset_aligner_reset got %h exp 0", aligner_reset_o); end
        reset_i = 1'b0;
        step(1);
    endtask

    task automatic test_lock();
        vfat_mask = ~24'h000001;
        step(2);
        tests++; if (vfat_ready[0] !== 1'b0) begin fails++; $display("FAIL lock_pre_ready got %b exp 0", vfat_ready[0]); end
        sot_is_aligned[0] = 1'b1;
        step(1);
        tests++; if (vfat_ready[0] !== 1'b1) begin fails++; $display("FAIL lock_ready_n1 got %b exp 1", vfat_ready[0]); end
        tests++; if (all_ready !== 1'b0) begin fails++; $display("FAIL lock_all_ready_n1 got %b exp 0", all_ready); end
        step(1);
        tests++; if (all_ready !== 1'b1) begin fails++; $display("FAIL lock_all_ready_n2 got %b exp 1", all_ready); end
        vfat_mask = '1;
        step(1);
        tests++; if (all_ready !== 1'b0) begin fails++; $display("FAIL all_masked_all_ready got %b exp 0", all_ready); end
        tests++; if (vfat_ready[0] !== 1'b0) begin fails++; $display("FAIL all_masked_ready0 got %b exp 0", vfat_ready[0]); end
        idle_all();
    endtask

    task automatic test_unlock_sat();
        vfat_mask = ~24'h000008;
        sot_is_aligned[3] = 1'b1;
        step(3);
        tests++; if (vfat_ready[3] !== 1'b1) begin fails++; $display("FAIL unlock_locked got %b exp 1", vfat_ready[3]); end
        sot_is_aligned[3] = 1'b0;
        step(1);
        tests++; if (vfat_ready[3] !== 1'b0) begin fails++; $display("FAIL unlock_ready_drop got %b exp 0", vfat_ready[3]); end
        tests++; if (cnt_of(3) !== 8'd1) begin fails++; $display("FAIL unlock_cnt_first got %0d exp 1", cnt_of(3)); end
        sot_is_aligned[3] = 1'b1;
        step(1);
        tests++; if (vfat_ready[3] !== 1'b1) begin fails++; $display("FAIL unlock_relock got %b exp 1", vfat_ready[3]); end
        for (int k = 0; k < 299; k++) begin
            sot_is_aligned[3] = 1'b0;
            step(1);
            sot_is_aligned[3] = 1'b1;
            step(1);
        end
        tests++; if (cnt_of(3) !== 8'd255) begin fails++; $display("FAIL unlock_cnt_saturate got %0d exp 255", cnt_of(3)); end
        tests++; if (cnt_of(0) !== 8'd0) begin fails++; $display("FAIL unlock_cnt_other got %0d exp 0", cnt_of(0)); end
        sot_is_aligned[3] = 1'b0;
        cnt_reset = 1'b1;
        step(1);
        cnt_reset = 1'b0;
        tests++; if (cnt_of(3) !== 8'd0) begin fails++; $display("FAIL cnt_reset_wins got %0d exp 0", cnt_of(3)); end
        tests++; if (vfat_ready[3] !== 1'b0) begin fails++; $display("FAIL cnt_reset_fsm_unlock got %b exp 0", vfat_ready[3]); end
        sot_is_aligned[3] = 1'b1;
        step(1);
        sot_is_aligned[3] = 1'b0;
        step(1);
        tests++; if (cnt_of(3) !== 8'd1) begin fails++; $display("FAIL unlock_cnt_after_clear got %0d exp 1", cnt_of(3)); end
        idle_all();
    endtask

    task automatic test_mask_mid_lock();
        vfat_mask      = ~24'h000060;
        sot_is_aligned = 24'h000060;
        step(3);
        tests++; if (vfat_ready !== 24'h000060) begin fails++; $display("FAIL mask_both_locked got %h exp 000060", vfat_ready); end
        step(1);
        tests++; if (all_ready !== 1'b1) begin fails++; $display("FAIL mask_all_ready_pre got %b exp 1", all_ready); end
        vfat_mask[5]      = 1'b1;
        sot_is_aligned[5] = 1'b0;
        step(1);
        tests++; if (vfat_ready !== 24'h000040) begin fails++; $display("FAIL mask_ready5_drop got %h exp 000040", vfat_ready); end
        tests++; if (all_ready !== 1'b1) begin fails++; $display("FAIL mask_all_ready_hold got %b exp 1", all_ready); end
        step(1);
        tests++; if (cnt_of(5) !== 8'd0) begin fails++; $display("FAIL mask_no_count got %0d exp 0", cnt_of(5)); end
        tests++; if (all_ready !== 1'b1) begin fails++; $display("FAIL mask_all_ready_hold2 got %b exp 1", all_ready); end
        sot_is_aligned[6] = 1'b0;
        step(1);
        tests++; if (vfat_ready[6] !== 1'b0) begin fails++; $display("FAIL mask_other_unlock got %b exp 0", vfat_ready[6]); end
        tests++; if (cnt_of(6) !== 8'd1) begin fails++; $display("FAIL mask_other_count got %0d exp 1", cnt_of(6)); end
        step(1);
        tests++; if (all_ready !== 1'b0) begin fails++; $display("FAIL mask_all_ready_drop got %b exp 0", all_ready); end
        idle_all();
    endtask

    task automatic test_unstable();
        vfat_mask    = ~24'h000004;
        step(2);
        sot_unstable = 24'h000084;
        step(1);
        tests++; if (unstable_err !== 24'h000004) begin fails++; $display("FAIL unstable_set got %h exp 000004", unstable_err); end
        sot_unstable = '0;
        step(5);
        tests++; if (unstable_err !== 24'h000004) begin fails++; $display("FAIL unstable_sticky got %h exp 000004", unstable_err); end
        sot_unstable[2] = 1'b1;
        cnt_reset       = 1'b1;
        step(1);
        cnt_reset = 1'b0;
        tests++; if (unstable_err !== '0) begin fails++; $display("FAIL unstable_clear_wins got %h exp 0", unstable_err); end
        step(3);
        tests++; if (unstable_err !== '0) begin fails++; $display("FAIL unstable_level_no_edge got %h exp 0", unstable_err); end
        idle_all();
    endtask

    task automatic test_timeout_disabled();
        align_timeout = '0;
        vfat_mask     = ~24'h000010;
        step(40);
        tests++; if (timeout_err !== '0) begin fails++; $display("FAIL timeout_disabled got %h exp 0", timeout_err); end
        tests++; if (aligner_reset_o !== '0) begin fails++; $display("FAIL timeout_disabled_areset got %h exp 0", aligner_reset_o); end
        idle_all();
    endtask

    task automatic test_timeout();
        align_timeout = 16'd20;
        vfat_mask     = ~24'h000002;
        step(21);
        tests++; if (timeout_err !== '0) begin fails++; $display("FAIL timeout_early got %h exp 0", timeout_err); end
        tests++; if (aligner_reset_o !== '0) begin fails++; $display("FAIL timeout_areset_early got %h exp 0", aligner_reset_o); end
        step(1);
        tests++; if (timeout_err !== 24'h000002) begin fails++; $display("FAIL timeout_rise got %h exp 000002", timeout_err); end
`ifdef SOT_AUTO_RETRY_EN
        tests++; if (aligner_reset_o !== 24'h000002) begin fails++; $display("FAIL retry_pulse_c1 got %h exp 000002", aligner_reset_o); end
        for (int k = 2; k <= 4; k++) begin
            step(1);
            tests++; if (aligner_reset_o !== 24'h000002) begin fails++; $display("FAIL retry_pulse_c%0d got %h exp 000002", k, aligner_reset_o); end
        end
        step(1);
        tests++; if (aligner_reset_o !== '0) begin fails++; $display("FAIL retry_pulse_end got %h exp 0", aligner_reset_o); end
        step(20);
        tests++; if (aligner_reset_o !== '0) begin fails++; $display("FAIL retry_gap got %h exp 0", aligner_reset_o); end
        step(1);
        tests++; if (aligner_reset_o !== 24'h000002) begin fails++; $display("FAIL retry_period got %h exp 000002", aligner_reset_o); end
`else
        for (int k = 0; k < 30; k++) begin
            tests++; if (aligner_reset_o !== '0) begin fails++; $display("FAIL no_retry_areset k=%0d got %h exp 0", k, aligner_reset_o); end
            step(1);
        end
        tests++; if (timeout_err !== 24'h000002) begin fails++; $display("FAIL timeout_stays got %h exp 000002", timeout_err); end
        sot_is_aligned[1] = 1'b1;
        step(1);
        tests++; if (vfat_ready[1] !== 1'b1) begin fails++; $display("FAIL late_lock got %b exp 1", vfat_ready[1]); end
`endif
        reset_i = 1'b1;
        step(1);
        tests++; if (aligner_reset_o !== '0) begin fails++; $display("FAIL midreset_areset got %h exp 0", aligner_reset_o); end
        tests++; if (vfat_ready !== '0 || all_ready !== 1'b0) begin fails++; $display("FAIL midreset_ready got %h/%b exp 0/0", vfat_ready, all_ready); end
        tests++; if (timeout_err !== '0 || unstable_err !== '0 || unlock_cnt !== '0) begin fails++; $display("FAIL midreset_status got %h/%h/%h exp 0", timeout_err, unstable_err, unlock_cnt); end
        reset_i = 1'b0;
        step(2);
    endtask

    initial begin
        reset_i        = 1'b1;
        sot_is_aligned = '0;
        sot_unstable   = '0;
        vfat_mask      = '1;
        align_timeout  = '0;
        cnt_reset      = 1'b0;
        test_reset();
        test_lock();
        test_unlock_sat();
        test_mask_mid_lock();
        test_unstable();
        test_timeout_disabled();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sot_monitor.md
# sot_monitor

Per-VFAT start-of-frame lock supervisor downstream of the trigger-path frame aligners. It consumes each aligner's `sot_is_aligned` / `sot_unstable` status and runs a small per-VFAT state machine that tracks lock acquisition, lock loss and acquisition timeout. It produces registered per-VFAT ready flags, an aggregate ready, sticky error flags and saturating unlock counters for slow control. It can also drive a per-VFAT aligner reset to retry alignment.

## Interface
Parameters:
- `NUM_VFATS`, 24, number of VFAT trigger links supervised
- `CNT_WIDTH`, 8, width of each saturating unlock counter
- `TIMEOUT_WIDTH`, 16, width of the acquisition timer and `align_timeout`

Ports:
- `clock`  in  1  40 MHz fabric clock; single clock domain
- `reset_i`  in  1  synchronous, active-high reset
- `sot_is_aligned`  in  NUM_VFATS  aligner lock status, one bit per VFAT
- `sot_unstable`  in  NUM_VFATS  aligner sticky instability flag, one bit per VFAT
- `vfat_mask`  in  NUM_VFATS  1 = VFAT excluded from supervision
- `align_timeout`  in  TIMEOUT_WIDTH  cycles allowed in WAIT_LOCK; 0 disables the timeout
- `cnt_reset`  in  1  synchronous clear of counters and sticky flags
- `vfat_ready`  out  NUM_VFATS  VFAT is in LOCKED
- `all_ready`  out  1  every unmasked VFAT is ready
- `timeout_err`  out  NUM_VFATS  sticky: acquisition timeout has occurred
- `unstable_err`  out  NUM_VFATS  sticky: a rising edge was seen on `sot_unstable`
- `unlock_cnt`  out  NUM_VFATS*CNT_WIDTH  packed saturating LOCKED→WAIT_LOCK counts; VFAT i occupies bits `[CNT_WIDTH*(i+1)-1 : CNT_WIDTH*i]`
- `aligner_reset_o`  out  NUM_VFATS  reset request to each frame aligner

## Operation
Per-VFAT FSM states: MASKED, WAIT_LOCK, LOCKED, RETRY.

Reset:
- State is WAIT_LOCK, or MASKED if the mask bit is set.
- Timer is 0.
- All outputs are 0, including `aligner_reset_o`.

State transitions:
- **Any state, `vfat_mask` = 1:** go to MASKED next cycle. `vfat_ready` = 0, `aligner_reset_o` = 0, timer held at 0, no counting, no error setting.
- **MASKED, `vfat_mask` = 0:** go to WAIT_LOCK with timer = 0.
- **WAIT_LOCK, timer:** increments each cycle and saturates at all-ones.
- **WAIT_LOCK, `sot_is_aligned` = 1:** go to LOCKED and clear the timer.
- **WAIT_LOCK, timeout:** when `align_timeout` ≠ 0 and timer == `align_timeout`, set `timeout_err`. Further behaviour is set under Configuration. Lock takes priority over timeout in the same cycle.
- **LOCKED, `sot_is_aligned` = 0:** go to WAIT_LOCK, clear the timer, and increment `unlock_cnt`. The count saturates at 2^CNT_WIDTH−1.
- **RETRY:** hold `aligner_reset_o` = 1 for exactly 4 cycles, then go to WAIT_LOCK with timer = 0. `sot_is_aligned` is ignored while in RETRY.

Error flags and counters:
- `unstable_err` is set on a 0→1 edge of `sot_unstable`, using a registered copy of the previous value, in any unmasked state.
- `cnt_reset` clears all `unlock_cnt`, `timeout_err` and `unstable_err` values. It does not change FSM state.
- If `cnt_reset` coincides with an increment or set event, `cnt_reset` wins and the result is 0.

Aggregate ready:
- `all_ready` = AND of (`vfat_ready` | `vfat_mask`) across all VFATs.
- If every VFAT is masked, `all_ready` = 0.

## Timing
- `sot_is_aligned` rising in WAIT_LOCK at cycle N → `vfat_ready` = 1 at N+1 → `all_ready` = 1 at N+2.
- `sot_is_aligned` falling in LOCKED at cycle N → `vfat_ready` = 0 and the `unlock_cnt` increment are both visible at N+1 → `all_ready` = 0 at N+2.
- The timeout compare is evaluated on the registered timer. With `align_timeout` = T, `timeout_err` rises T+1 cycles after entering WAIT_LOCK.
- `aligner_reset_o` is registered: it is high for cycles N+1..N+4 when RETRY is entered at N+1.
- `reset_i` mid-operation aborts RETRY immediately: `aligner_reset_o` = 0 on the next cycle.
- All outputs are registered. There is no combinational input-to-output path.

## Configuration
- **`SOT_AUTO_RETRY_EN` defined:** a timeout in WAIT_LOCK moves the FSM to RETRY, which pulses `aligner_reset_o`. The retry repeats indefinitely.
- **`SOT_AUTO_RETRY_EN` undefined:**
  - A timeout only sets `timeout_err`. The FSM stays in WAIT_LOCK with the timer saturated, and locks normally if alignment later arrives.
  - The RETRY state is not compiled.
  - `aligner_reset_o` is tied to 0.

## Structure
- Shared package `sot_monitor_pkg` holds:
  - the state enum (MASKED, WAIT_LOCK, LOCKED, RETRY);
  - the `RETRY_CYCLES` = 4 constant;
  - default widths.
- Sub-module `sot_monitor_channel` contains one VFAT's FSM, timer, counter and sticky flags.
- The top level generates `NUM_VFATS` instances of `sot_monitor_channel` and contains the registered `all_ready` reduction.

## Test plan
- **Lock:** `vfat_mask` = 0, raise `sot_is_aligned[0]` at cycle 10 → `vfat_ready[0]` = 1 at 11. With all other VFATs masked, `all_ready` = 1 at 12.
- **Unlock and saturation:** toggle `sot_is_aligned[3]` 300 times with `CNT_WIDTH` = 8 → `unlock_cnt[3]` = 255. Then pulse `cnt_reset` coincident with one more unlock → 0.
- **Timeout:** `align_timeout` = 20, never align → `timeout_err` rises 21 cycles after entering WAIT_LOCK.
  - With `SOT_AUTO_RETRY_EN`: `aligner_reset_o` high for exactly 4 cycles, repeating every 25 cycles.
  - Without it: `aligner_reset_o` stays 0.
- **Mask mid-lock:** LOCKED, set `vfat_mask[5]` → `vfat_ready[5]` = 0 next cycle and no `unlock_cnt` increment. `all_ready` still reflects the other VFATs.
- **Instability and reset:** pulse `sot_unstable[2]` → `unstable_err[2]` = 1 and sticky. Assert `reset_i` during RETRY → all outputs 0 the next cycle.
